// File: rtl/fp_div_unpack.sv
// fp_div_unpack: registers an fp32 operand pair, resolves IEEE special cases and
// forwards finite pairs to the divider, with a one-beat skid for backpressure.
module fp_div_unpack #(
  parameter bit          FTZ  = 1'b1,
  parameter logic [31:0] QNAN = 32'h7FC00000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] operand_a,
  input  logic [31:0] operand_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_a,
  output logic [31:0] out_b,
  output logic        out_special,
  output logic [31:0] out_result,
  output logic        out_invalid,
  output logic        out_divzero
);
  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic        special;
    logic [31:0] result;
    logic        invalid;
    logic        divzero;
  } beat_t;
  beat_t nxt, out_q, skid_q;
  logic skid_valid, acc, s;
  logic [31:0] fa, fb;
  logic ea_max, eb_max, na, nb, sna, snb, ia, ib, za, zb;
  assign ea_max = &operand_a[30:23];
  assign eb_max = &operand_b[30:23];
  assign fa = (FTZ && operand_a[30:23] == 8'h0) ? {operand_a[31], 31'h0} : operand_a;
  assign fb = (FTZ && operand_b[30:23] == 8'h0) ? {operand_b[31], 31'h0} : operand_b;
  assign na = ea_max && operand_a[22:0] != 23'h0;
  assign nb = eb_max && operand_b[22:0] != 23'h0;
  assign sna = na && !operand_a[22];
  assign snb = nb && !operand_b[22];
  assign ia = ea_max && operand_a[22:0] == 23'h0;
  assign ib = eb_max && operand_b[22:0] == 23'h0;
  assign za = fa[30:0] == 31'h0;
  assign zb = fb[30:0] == 31'h0;
  assign s = operand_a[31] ^ operand_b[31];
  // First matching rule wins; non-special pairs carry a zero result and no flags.
  always_comb begin
    nxt = '0;
    nxt.a = fa;
    nxt.b = fb;
    if (na || nb) begin
      nxt.special = 1'b1;
      nxt.result = QNAN;
      nxt.invalid = sna || snb;
    end else if ((ia && ib) || (za && zb)) begin
      nxt.special = 1'b1;
      nxt.result = QNAN;
      nxt.invalid = 1'b1;
    end else if (ia) begin
      nxt.special = 1'b1;
      nxt.result = {s, 8'hFF, 23'h0};
    end else if (ib) begin
      nxt.special = 1'b1;
      nxt.result = {s, 31'h0};
    end else if (zb) begin
      nxt.special = 1'b1;
      nxt.result = {s, 8'hFF, 23'h0};
      nxt.divzero = 1'b1;
    end else if (za) begin
      nxt.special = 1'b1;
      nxt.result = {s, 31'h0};
    end
  end
  assign in_ready = !skid_valid;
  assign acc = in_valid && in_ready;
  // The skid only fills while the output is stalled, so it is empty whenever the output is.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      skid_valid <= 1'b0;
      out_q <= '0;
      skid_q <= '0;
    end else if (!out_valid || out_ready) begin
      out_valid <= skid_valid || acc;
      out_q <= skid_valid ? skid_q : acc ? nxt : out_q;
      skid_valid <= 1'b0;
    end else if (acc) begin
      skid_q <= nxt;
      skid_valid <= 1'b1;
    end
  end
  assign out_a = out_q.a;
  assign out_b = out_q.b;
  assign out_special = out_q.special;
  assign out_result = out_q.result;
  assign out_invalid = out_q.invalid;
  assign out_divzero = out_q.divzero;
endmodule

// File: tb/tb_fp_div_unpack.sv
// tb_fp_div_unpack: directed and randomized checks of fp_div_unpack (FTZ=0 and FTZ=1)
// against a classification-based reference model and an in-order scoreboard.
module tb_fp_div_unpack;
  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic        sp;
    logic [31:0] res;
    logic        inv;
    logic        dz;
  } beat_t;
  localparam logic [31:0] QNAN = 32'h7FC00000;
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] operand_a = '0, operand_b = '0;
  logic rdy[2], ov[2], osp[2], oinv[2], odz[2];
  logic [31:0] oa[2], ob[2], ores[2];
  int n_tests = 0, n_fail = 0;
  always #5 clk = ~clk;
  fp_div_unpack #(.FTZ(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[0]),
    .operand_a(operand_a), .operand_b(operand_b), .out_valid(ov[0]), .out_ready(out_ready),
    .out_a(oa[0]), .out_b(ob[0]), .out_special(osp[0]), .out_result(ores[0]),
    .out_invalid(oinv[0]), .out_divzero(odz[0])
  );
  fp_div_unpack #(.FTZ(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[1]),
    .operand_a(operand_a), .operand_b(operand_b), .out_valid(ov[1]), .out_ready(out_ready),
    .out_a(oa[1]), .out_b(ob[1]), .out_special(osp[1]), .out_result(ores[1]),
    .out_invalid(oinv[1]), .out_divzero(odz[1])
  );
  task automatic check(input string tag, input logic [98:0] got, input logic [98:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // 0 finite nonzero, 1 zero, 2 inf, 3 quiet NaN, 4 signalling NaN
  function automatic int kind(input logic [31:0] x, input bit ftz);
    if (x[30:23] == 8'hFF) return x[22:0] == 0 ? 2 : x[22] ? 3 : 4;
    if (x[30:23] == 8'h00 && (x[22:0] == 0 || ftz)) return 1;
    return 0;
  endfunction
  function automatic beat_t model(input logic [31:0] a, input logic [31:0] b, input bit ftz);
    beat_t r = '0;
    int ka = kind(a, ftz), kb = kind(b, ftz);
    logic s = a[31] ^ b[31];
    r.a = (ftz && a[30:23] == 0) ? {a[31], 31'h0} : a;
    r.b = (ftz && b[30:23] == 0) ? {b[31], 31'h0} : b;
    r.sp = 1'b1;
    if (ka >= 3 || kb >= 3) begin r.res = QNAN; r.inv = (ka == 4 || kb == 4); end
    else if (ka == kb && (ka == 1 || ka == 2)) begin r.res = QNAN; r.inv = 1'b1; end
    else if (ka == 2) r.res = {s, 8'hFF, 23'h0};
    else if (kb == 2) r.res = {s, 31'h0};
    else if (kb == 1) begin r.res = {s, 8'hFF, 23'h0}; r.dz = 1'b1; end
    else if (ka == 1) r.res = {s, 31'h0};
    else r.sp = 1'b0;
    return r;
  endfunction
  function automatic logic [31:0] rnd_op();
    logic [31:0] r = $urandom();
    case ($urandom_range(0, 8))
      0: return {r[31], 31'h0};
      1: return {r[31], 8'hFF, 23'h0};
      2: return {r[31], 8'hFF, 1'b1, r[21:0]};
      3: return {r[31], 8'hFF, 1'b0, r[21:1], 1'b1};
      4: return {r[31], 8'h00, r[22:1], 1'b1};
      5: return 32'h3F800000;
      default: return r;
    endcase
  endfunction
  for (genvar g = 0; g < 2; g++) begin : mon
    beat_t sb[$];
    beat_t hb, cur, e;
    bit held = 0;
    always @(negedge clk) begin
      cur = {oa[g], ob[g], osp[g], ores[g], oinv[g], odz[g]};
      if (!rst_n) begin
        sb.delete();
        held = 0;
      end else begin
        if (held) begin
          check("hold_valid", ov[g], 1'b1);
          check("hold_data", cur, hb);
        end
        held = ov[g] && !out_ready;
        hb = cur;
        if (ov[g] && out_ready) begin
          check("sb_nonempty", sb.size() != 0, 1'b1);
          if (sb.size() != 0) begin
            e = sb.pop_front();
            check("sb_special", osp[g], e.sp);
            check("sb_result", ores[g], e.res);
            check("sb_invalid", oinv[g], e.inv);
            check("sb_divzero", odz[g], e.dz);
            if (!e.sp) begin
              check("sb_a", oa[g], e.a);
              check("sb_b", ob[g], e.b);
            end
          end
        end
        if (in_valid && rdy[g]) sb.push_back(model(operand_a, operand_b, g != 0));
      end
    end
  end
  logic [31:0] ta[14] = '{32'h40400000, 32'h3F800000, 32'hBF800000, 32'h00000000, 32'h7F800000,
    32'h7F800001, 32'h7FC00000, 32'h00000001, 32'h7F800000, 32'h3F800000, 32'h80000000,
    32'h3F800000, 32'h00000001, 32'h3F800000};
  logic [31:0] tb_[14] = '{32'h3FC00000, 32'h00000000, 32'h00000000, 32'h00000000, 32'h7F800000,
    32'h3F800000, 32'h3F800000, 32'h3F800000, 32'hBF800000, 32'hFF800000, 32'h3F800000,
    32'h00000001, 32'h80000001, 32'h7FA00000};
  logic [31:0] tr[14] = '{32'h0, 32'h7F800000, 32'hFF800000, QNAN, QNAN, QNAN, QNAN, 32'h0,
    32'hFF800000, 32'h80000000, 32'h80000000, 32'h7F800000, QNAN, QNAN};
  logic tsp[14] = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1};
  logic tinv[14] = '{0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 1, 1};
  logic tdz[14] = '{0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
  logic [31:0] pa[4] = '{32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000};
  logic [31:0] pb[4] = '{32'h3F800000, 32'h3FC00000, 32'h40000000, 32'h40200000};
  initial begin
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      check("rst_valid", ov[d], 1'b0);
      check("rst_ready", rdy[d], 1'b1);
      check("rst_data", {oa[d], ob[d], osp[d], ores[d], oinv[d], odz[d]}, '0);
    end
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 14; i++) begin
      operand_a = ta[i];
      operand_b = tb_[i];
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      check("dir_valid", ov[1], 1'b1);
      check("dir_special", osp[1], tsp[i]);
      check("dir_result", ores[1], tr[i]);
      check("dir_invalid", oinv[1], tinv[i]);
      check("dir_divzero", odz[1], tdz[i]);
      if (!tsp[i]) check("dir_ab", {oa[1], ob[1]}, {ta[i], tb_[i]});
      if (ta[i] == 32'h00000001 && tb_[i] == 32'h3F800000) begin
        check("noftz_special", osp[0], 1'b0);
        check("noftz_a", oa[0], 32'h00000001);
      end
    end
    @(posedge clk);
    #1;
    operand_a = pa[0];
    operand_b = pb[0];
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    check("strm_ready1", rdy[1], 1'b1);
    out_ready = 1'b0;
    operand_a = pa[1];
    operand_b = pb[1];
    @(posedge clk);
    #1;
    check("strm_ready2", rdy[1], 1'b0);
    operand_a = pa[2];
    operand_b = pb[2];
    repeat (2) @(posedge clk);
    #1;
    check("strm_held", oa[1], pa[0]);
    check("strm_ready4", rdy[1], 1'b0);
    out_ready = 1'b1;
    begin
      int k = 2;
      for (int n = 0; n < 20 && k < 4; n++) begin
        logic go;
        operand_a = pa[k];
        operand_b = pb[k];
        go = rdy[1];
        @(posedge clk);
        #1;
        if (go) k++;
      end
      check("strm_sent", k, 4);
    end
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("strm_drain", mon[1].sb.size(), 0);
    for (int c = 0; c < 3000; c++) begin
      operand_a = rnd_op();
      operand_b = rnd_op();
      in_valid = $urandom_range(0, 3) != 0;
      out_ready = $urandom_range(0, 2) != 0;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("drain0", mon[0].sb.size(), 0);
    check("drain1", mon[1].sb.size(), 0);
    out_ready = 1'b0;
    in_valid = 1'b1;
    operand_a = pa[3];
    operand_b = pb[3];
    repeat (2) @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("full_ready", rdy[1], 1'b0);
    check("full_valid", ov[1], 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", ov[1], 1'b0);
    check("arst_ready", rdy[1], 1'b1);
    check("arst_data", {oa[1], ob[1], osp[1], ores[1], oinv[1], odz[1]}, '0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      check("post_rst_valid", ov[1] | ov[0], 1'b0);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
